// File: rtl/mod_pkg.sv
// Shared definitions for the washing-machine controller.
//   state_e : 3-bit state encoding, also driven out on S
//   max_u   : helper for sizing the tick counter from the phase lengths
package mod_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StWarm  = 3'd2,
    StWash  = 3'd3,
    StDrain = 3'd4,
    StDry   = 3'd5,
    StDone  = 3'd6
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mod_clkdiv.sv
// Free-running prescaler for the washing-machine controller.
//   clk   : system clock (rising edge)
//   rst_n : synchronous active-low reset
//   tick  : one-cycle strobe every DIV clocks (when the count reaches DIV-1)
//   f     : divided clock, toggles on every tick (period 2*DIV)
module mod_clkdiv #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic f
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            f_q;

  assign tick = (cnt_q == CntMax);
  assign f    = f_q;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      f_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (tick) begin
        f_q <= ~f_q;
      end
    end
  end

endmodule

// File: rtl/mod.sv
// Washing-machine sequencer: IDLE -> FILL -> [WARM] -> WASH -> DRAIN -> DRY -> DONE.
//   inpFreq        : system clock (rising edge)
//   rst_n          : synchronous active-low reset
//   washingProgram : 1 = warm program, 0 = cold (skips WARM); latched on leaving IDLE
//   faucet         : water available; FILL pauses without it
//   door           : 1 = open; pauses every timed phase and blocks start
//   do_req         : level-sensitive start request ("do" is a reserved word in SV)
//   fill..dry      : registered actuator enables, one-hot while running
//   f              : registered divided clock from the prescaler
//   S              : registered state code
module mod
  import mod_pkg::*;
#(
  parameter int unsigned DIV     = 2,
  parameter int unsigned FILL_T  = 3,
  parameter int unsigned WARM_T  = 2,
  parameter int unsigned WASH_T  = 4,
  parameter int unsigned DRAIN_T = 2,
  parameter int unsigned DRY_T   = 3
) (
  input  logic       inpFreq,
  input  logic       rst_n,
  input  logic       washingProgram,
  input  logic       faucet,
  input  logic       door,
  input  logic       do_req,
  output logic       fill,
  output logic       warm,
  output logic       wash,
  output logic       drain,
  output logic       dry,
  output logic       f,
  output logic [2:0] S
);

  localparam int unsigned MaxT =
      max_u(max_u(max_u(FILL_T, WARM_T), max_u(WASH_T, DRAIN_T)), DRY_T);
  localparam int unsigned TcntW = $clog2(MaxT + 1);

  logic             tick;
  state_e           state_q, state_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic [TcntW-1:0] t_last;
  logic             prog_q, prog_d;
  logic             running, run_next;
  logic [4:0]       act_q, act_d;  // {fill, warm, wash, drain, dry}

  mod_clkdiv #(
    .DIV(DIV)
  ) u_clkdiv (
    .clk  (inpFreq),
    .rst_n(rst_n),
    .tick (tick),
    .f    (f)
  );

  // Last counter value of the current timed phase.
  always_comb begin
    t_last = '0;
    case (state_q)
      StFill:  t_last = TcntW'(FILL_T - 1);
      StWarm:  t_last = TcntW'(WARM_T - 1);
      StWash:  t_last = TcntW'(WASH_T - 1);
      StDrain: t_last = TcntW'(DRAIN_T - 1);
      StDry:   t_last = TcntW'(DRY_T - 1);
      default: t_last = '0;
    endcase
  end

  assign running = !door && ((state_q != StFill) || faucet);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    prog_d  = prog_q;
    case (state_q)
      StIdle: begin
        if (do_req && !door) begin
          state_d = StFill;
          prog_d  = washingProgram;
          tcnt_d  = '0;
        end
      end
      StFill, StWarm, StWash, StDrain, StDry: begin
        if (running && tick) begin
          if (tcnt_q == t_last) begin
            tcnt_d = '0;
            case (state_q)
              StFill:  state_d = prog_q ? StWarm : StWash;
              StWarm:  state_d = StWash;
              StWash:  state_d = StDrain;
              StDrain: state_d = StDry;
              default: state_d = StDone;
            endcase
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (!do_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Actuators are registered from the next state so they line up with S.
  assign run_next = !door && ((state_d != StFill) || faucet);

  always_comb begin
    act_d = 5'b00000;
    if (run_next) begin
      case (state_d)
        StFill:  act_d = 5'b10000;
        StWarm:  act_d = 5'b01000;
        StWash:  act_d = 5'b00100;
        StDrain: act_d = 5'b00010;
        StDry:   act_d = 5'b00001;
        default: act_d = 5'b00000;
      endcase
    end
  end

  always_ff @(posedge inpFreq) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
      prog_q  <= 1'b0;
      act_q   <= 5'b00000;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      prog_q  <= prog_d;
      act_q   <= act_d;
    end
  end

  assign {fill, warm, wash, drain, dry} = act_q;
  assign S = state_q;

endmodule

// File: tb/tb_mod.sv
// Self-checking bench for mod: a cycle model of the controller pushes the expected
// S/actuators/f to a queue before each edge; the entry is popped and compared after it.
module tb_mod;

  localparam int unsigned DIV     = 2;
  localparam int unsigned FILL_T  = 3;
  localparam int unsigned WARM_T  = 2;
  localparam int unsigned WASH_T  = 4;
  localparam int unsigned DRAIN_T = 2;
  localparam int unsigned DRY_T   = 3;

  logic       clk = 1'b0;
  logic       rst_n, prog, faucet, door, do_req;
  logic       fill, warm, wash, drain, dry, f;
  logic [2:0] S;

  mod #(
    .DIV    (DIV),
    .FILL_T (FILL_T),
    .WARM_T (WARM_T),
    .WASH_T (WASH_T),
    .DRAIN_T(DRAIN_T),
    .DRY_T  (DRY_T)
  ) dut (
    .inpFreq       (clk),
    .rst_n         (rst_n),
    .washingProgram(prog),
    .faucet        (faucet),
    .door          (door),
    .do_req        (do_req),
    .fill          (fill),
    .warm          (warm),
    .wash          (wash),
    .drain         (drain),
    .dry           (dry),
    .f             (f),
    .S             (S)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] s;
    logic [4:0] act;
    logic       f;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   hist[8];
  int   warm_seen;

  // Reference model state: phases count remaining ticks down.
  int         m_pre, m_st, m_left;
  logic       m_f, m_prog;
  logic [4:0] m_act;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input int st);
    case (st)
      1: return FILL_T;
      2: return WARM_T;
      3: return WASH_T;
      4: return DRAIN_T;
      5: return DRY_T;
      default: return 0;
    endcase
  endfunction

  task automatic model_update();
    bit tk;
    bit run;
    if (!rst_n) begin
      m_pre = 0; m_f = 1'b0; m_st = 0; m_left = 0; m_prog = 1'b0; m_act = 5'b0;
      return;
    end
    tk    = (m_pre == int'(DIV) - 1);
    m_pre = tk ? 0 : m_pre + 1;
    if (tk) m_f = !m_f;
    run = !door && (m_st != 1 || faucet);
    case (m_st)
      0: if (do_req && !door) begin
        m_st = 1; m_prog = prog; m_left = FILL_T;
      end
      1, 2, 3, 4, 5: if (run && tk) begin
        m_left--;
        if (m_left == 0) begin
          m_st   = (m_st == 1) ? (m_prog ? 2 : 3) : m_st + 1;
          m_left = dur(m_st);
        end
      end
      6: if (!do_req) m_st = 0;
      default: m_st = 0;
    endcase
    run   = !door && (m_st != 1 || faucet);
    m_act = (m_st >= 1 && m_st <= 5 && run) ? (5'b10000 >> (m_st - 1)) : 5'b00000;
  endtask

  task automatic step();
    exp_t e;
    model_update();
    e.s   = 3'(m_st);
    e.act = m_act;
    e.f   = m_f;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("S", 32'(S), 32'(e.s));
    check("act", 32'({fill, warm, wash, drain, dry}), 32'(e.act));
    check("f", 32'(f), 32'(e.f));
    hist[S]++;
    if (warm === 1'b1) warm_seen++;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    warm_seen = 0;
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (m_st != target && n < budget) begin
      step();
      n++;
    end
    if (m_st != target) check("timeout", 32'(m_st), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; prog = 1'b0; faucet = 1'b1; door = 1'b0; do_req = 1'b1;
    clear_hist();

    // Reset with start requested
    repeat (3) step();
    check("rst_S", 32'(S), 0);
    check("rst_f", 32'(f), 0);

    // Warm program
    rst_n = 1'b1; prog = 1'b1; faucet = 1'b1; door = 1'b0; do_req = 1'b1;
    clear_hist();
    run_until(6, 200);
    repeat (3) step();
    check("warm_fill_len", 32'(hist[1] == 5 || hist[1] == 6), 1);
    check("warm_warm_len", 32'(hist[2]), 4);
    check("warm_wash_len", 32'(hist[3]), 8);
    check("warm_drain_len", 32'(hist[4]), 4);
    check("warm_dry_len", 32'(hist[5]), 6);
    check("done_hold", 32'(S), 6);
    do_req = 1'b0;
    step();
    check("done_exit", 32'(S), 0);

    // Program latched: drop it during WASH
    prog = 1'b1; do_req = 1'b1;
    clear_hist();
    run_until(3, 100);
    prog = 1'b0;
    run_until(6, 200);
    check("latch_warm_len", 32'(hist[2]), 4);
    check("latch_wash_len", 32'(hist[3]), 8);
    do_req = 1'b0;
    step();

    // Cold program
    prog = 1'b0; do_req = 1'b1;
    clear_hist();
    run_until(6, 200);
    check("cold_no_warm_state", 32'(hist[2]), 0);
    check("cold_no_warm_out", 32'(warm_seen), 0);
    check("cold_wash_len", 32'(hist[3]), 8);
    do_req = 1'b0;
    step();

    // Faucet loss after one FILL tick
    prog = 1'b1; faucet = 1'b1; do_req = 1'b1;
    n = 0;
    while (!(m_st == 1 && m_left == int'(FILL_T) - 1) && n < 50) begin
      step();
      n++;
    end
    if (!(m_st == 1 && m_left == int'(FILL_T) - 1)) check("timeout_fill", 32'(m_st), 1);
    faucet = 1'b0;
    repeat (20) step();
    check("faucet_S", 32'(S), 1);
    check("faucet_fill", 32'(fill), 0);
    faucet = 1'b1;
    run_until(6, 200);
    do_req = 1'b0;
    step();

    // Door open blocks start, then pauses WASH
    door = 1'b1; do_req = 1'b1;
    repeat (5) step();
    check("door_idle", 32'(S), 0);
    door = 1'b0;
    run_until(3, 100);
    repeat (3) step();
    door = 1'b1;
    repeat (10) step();
    check("door_wash_S", 32'(S), 3);
    check("door_wash_out", 32'(wash), 0);
    door = 1'b0;
    run_until(6, 200);
    do_req = 1'b0;
    step();

    // Reset during DRAIN
    do_req = 1'b1;
    run_until(4, 200);
    step();
    rst_n = 1'b0;
    step();
    check("drain_rst", 32'(S), 0);
    rst_n = 1'b1; do_req = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod.md
MOD -- requirements
Module: mod

Interface
REQ-001 Parameter DIV, default 2: inpFreq cycles per tick; f toggles once per tick; minimum 1.
REQ-002 Parameter FILL_T, default 3: ticks spent filling.
REQ-003 Parameter WARM_T, default 2: ticks spent warming.
REQ-004 Parameter WASH_T, default 4: ticks spent washing.
REQ-005 Parameter DRAIN_T, default 2: ticks spent draining.
REQ-006 Parameter DRY_T, default 3: ticks spent drying.
REQ-007 Port inpFreq, input, 1: the single system clock; all logic uses its rising edge.
REQ-008 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-009 Port washingProgram, input, 1: 1 = warm program (includes WARM), 0 = cold program (skips WARM).
REQ-010 Port faucet, input, 1: water supply available.
REQ-011 Port door, input, 1: 1 = door open, 0 = closed.
REQ-012 Port do, input, 1: start request, level-sensitive.
REQ-013 Ports fill, warm, wash, drain, dry, outputs, 1 each: actuator enables, all registered.
REQ-014 Port f, output, 1: divided clock, registered.
REQ-015 Port S, output, 3: current state code, registered.

Function
REQ-016 Free-running prescaler counts 0..DIV-1; tick is high for one cycle when the count equals DIV-1; f toggles on every tick.
REQ-017 State codes: IDLE=0, FILL=1, WARM=2, WASH=3, DRAIN=4, DRY=5, DONE=6; code 7 returns to IDLE on the next cycle.
REQ-018 IDLE: all actuators 0; if do=1 and door=0, go to FILL on the next edge, latch washingProgram, and clear the tick counter.
REQ-019 washingProgram is sampled only on leaving IDLE; later changes have no effect on the current cycle of operation.
REQ-020 In each timed state (FILL..DRY), the tick counter increments on tick while running; on the tick that completes the state's T ticks, the FSM moves to the next state and clears the counter.
REQ-021 Timed-state sequence: FILL -> WARM (latched program=1) or WASH (latched program=0); WARM -> WASH -> DRAIN -> DRY -> DONE.
REQ-022 Running condition: door=0, and additionally faucet=1 while in FILL; when not running, the counter holds and S holds.
REQ-023 Actuator outputs: exactly the actuator named by the current state is 1 while running, else 0; all five are 0 in IDLE, DONE and while paused.
REQ-024 DONE: all actuators 0; stay while do=1; go to IDLE on the first cycle do=0.
REQ-025 The prescaler is never affected by the FSM; tick phase is free-running.
REQ-026 S changes with the registered state, so outputs and S are consistent in the same cycle.

Reset
REQ-027 When rst_n=0 at a rising edge: S=0, fill=warm=wash=drain=dry=0, f=0, prescaler=0, tick counter=0, latched program=0.
REQ-028 Reset overrides all other inputs, including mid-operation; after reset, the FSM restarts from IDLE.

Structure
REQ-029 Package mod_pkg holds the state encoding constants (IDLE..DONE, width 3).
REQ-030 One sub-module, mod_clkdiv, holds the prescaler and generates tick and f; the FSM and tick counter live in mod.

Verification
REQ-031 Reset: rst_n=0 for 3 cycles with do=1 -> S=0, all actuators 0, f=0.
REQ-032 Warm run with defaults: program=1, faucet=1, door=0, do=1 -> S steps 1,2,3,4,5,6 holding 3,2,4,2,3 ticks (6,4,8,4,6 cycles); exactly one matching actuator is high; f period is 4 cycles.
REQ-033 Latching: start with program=1, then drop program to 0 during WASH -> the sequence completes unchanged. Start with program=0 -> S goes 1,3,4,5,6 and warm is never 1.
REQ-034 Faucet loss: faucet=0 after 1 FILL tick -> fill=0 and S=1 held indefinitely; faucet=1 -> exactly 2 more ticks, then advance.
REQ-035 Door: door=1 with do=1 in IDLE -> S stays 0. door=1 mid-WASH -> wash=0 and the counter frozen; door=0 -> the remaining WASH ticks complete.
REQ-036 Completion: DONE with do held -> S=6 and all outputs 0; do=0 -> S=0 on the next edge; rst_n=0 during DRAIN -> S=0 on the next edge.
